// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  // Stall bus bit positions
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EXB = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_IDS  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_RUN  = 1'b1
  } mc_state_e;

  // An ID/EX bubble: ID is held while EX is allowed to advance.
  function automatic logic is_bubble(input logic [STALL_W-1:0] s);
    return (s[STALL_ID] == STOP) && (s[STALL_EXB] == NOT_STOP);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges the ID stall request with a multi-cycle
// EX occupancy tracker, applies flush priority and keeps perf counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MC_IDLE | no multi-cycle op outstanding; mc_start may launch one
//   MC_RUN  | op in flight; cnt = cycles left incl. the final release cycle
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int LEN_W = 6,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               mc_start,
  input  logic [LEN_W-1:0]   mc_len,
  input  logic               flush,
  input  logic               perf_clr,
  output logic [STALL_W-1:0] stall,
  output logic               mc_busy,
  output logic               mc_done,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   bubble_cnt
);

  mc_state_e        state;
  logic [LEN_W-1:0] cnt;
  logic             launch_long;
  logic             launch_short;
  logic             req_ex;

  // Decode the EX request and completion from state and this cycle's inputs.
  always_comb begin
    launch_long  = (state == MC_IDLE) && mc_start && (mc_len >= LEN_W'(2));
    launch_short = (state == MC_IDLE) && mc_start && (mc_len <= LEN_W'(1));
    req_ex       = 1'b0;
    mc_done      = 1'b0;
    if (!rst && !flush) begin
      req_ex  = launch_long || ((state == MC_RUN) && (cnt > LEN_W'(1)));
      mc_done = launch_short || ((state == MC_RUN) && (cnt == LEN_W'(1)));
    end
  end

  // Stall bus priority: flush, then EX occupancy, then ID request.
  always_comb begin
    stall = STALL_NONE;
    if (rst || flush) begin
      stall = STALL_NONE;
    end else if (req_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_IDS;
    end
  end

  assign mc_busy = !rst && (state == MC_RUN);

  // Multi-cycle tracker; a new mc_start while running is ignored.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (launch_long) begin
            state <= MC_RUN;
            cnt   <= mc_len - LEN_W'(1);
          end
        end
        MC_RUN: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt <= LEN_W'(1)) begin
            state <= MC_IDLE;
          end
        end
        default: begin
          state <= MC_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic cnt_clr;
  assign cnt_clr = rst || perf_clr;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .inc (stall != STALL_NONE),
    .clr (cnt_clr),
    .q   (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .inc (is_bubble(stall)),
    .clr (cnt_clr),
    .q   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with a per-cycle scoreboard.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stallreq_id, mc_start, flush, perf_clr;
  logic [5:0]  mc_len;
  logic [5:0]  stall;
  logic        mc_busy, mc_done;
  logic [31:0] stall_cycles, bubble_cnt;

  logic        rst4, id4, clr4;
  logic [5:0]  stall4;
  logic        busy4, done4;
  logic [3:0]  sc4, bc4;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
    .mc_len(mc_len), .flush(flush), .perf_clr(perf_clr), .stall(stall),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stall_ctrl #(.LEN_W(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .stallreq_id(id4), .mc_start(1'b0),
    .mc_len(6'd0), .flush(1'b0), .perf_clr(clr4), .stall(stall4),
    .mc_busy(busy4), .mc_done(done4), .stall_cycles(sc4), .bubble_cnt(bc4)
  );

  typedef struct {
    string      tag;
    logic [5:0] stall;
    logic       busy;
    logic       done;
    logic       clr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_stall_cyc, m_bubble;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, push expectation, sample at negedge, pop and compare.
  task automatic cycle(input string tag, input logic id, input logic st,
                       input logic [5:0] len, input logic fl, input logic clr,
                       input logic [5:0] e_stall, input logic e_busy, input logic e_done);
    exp_t e, o;
    @(posedge clk); #1;
    stallreq_id = id; mc_start = st; mc_len = len; flush = fl; perf_clr = clr;
    e.tag = tag; e.stall = e_stall; e.busy = e_busy; e.done = e_done; e.clr = clr;
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    check({o.tag, ".stall"}, 32'(stall), 32'(o.stall));
    check({o.tag, ".busy"}, 32'(mc_busy), 32'(o.busy));
    check({o.tag, ".done"}, 32'(mc_done), 32'(o.done));
    check({o.tag, ".stall_cycles"}, stall_cycles, m_stall_cyc);
    check({o.tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
    if (o.clr) begin
      m_stall_cyc = 0;
      m_bubble = 0;
    end else begin
      if (o.stall != 6'b0 && m_stall_cyc != 32'hFFFF_FFFF) m_stall_cyc++;
      if (o.stall[2] && !o.stall[3] && m_bubble != 32'hFFFF_FFFF) m_bubble++;
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b1; mc_start = 1'b1; mc_len = 6'd5;
    flush = 1'b0; perf_clr = 1'b0;
    rst4 = 1'b1; id4 = 1'b0; clr4 = 1'b0;
    m_stall_cyc = 0; m_bubble = 0;

    // Reset held 3 cycles with inputs active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.busy", 32'(mc_busy), 32'd0);
      check("rst.done", 32'(mc_done), 32'd0);
      if (i > 0) begin
        check("rst.stall_cycles", stall_cycles, 32'd0);
        check("rst.bubble_cnt", bubble_cnt, 32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; rst4 = 1'b0; stallreq_id = 1'b0; mc_start = 1'b0;
    @(negedge clk);
    check("idle.stall", 32'(stall), 32'd0);

    // ID stall for two cycles
    cycle("id1", 1, 0, 0, 0, 0, 6'b000111, 0, 0);
    cycle("id2", 1, 0, 0, 0, 0, 6'b000111, 0, 0);
    cycle("id_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    check("id.bubble_total", bubble_cnt, 32'd2);
    check("id.stall_total", stall_cycles, 32'd2);

    // mc_len=5
    cycle("mc5_c1", 0, 1, 5, 0, 0, 6'b001111, 0, 0);
    cycle("mc5_c2", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cycle("mc5_c3", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cycle("mc5_c4", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cycle("mc5_c5", 0, 0, 0, 0, 0, 6'b000000, 1, 1);
    cycle("mc5_c6", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // mc_len=2 with concurrent ID request
    cycle("mc2id_c1", 1, 1, 2, 0, 0, 6'b001111, 0, 0);
    cycle("mc2id_c2", 1, 0, 0, 0, 0, 6'b000111, 1, 1);
    cycle("mc2id_c3", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Short ops
    cycle("mc1", 0, 1, 1, 0, 0, 6'b000000, 0, 1);
    cycle("mc0", 0, 1, 0, 0, 0, 6'b000000, 0, 1);
    cycle("short_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // mc_len=20 flushed at cycle 6
    cycle("mc20_c1", 0, 1, 20, 0, 0, 6'b001111, 0, 0);
    for (int i = 2; i <= 5; i++)
      cycle("mc20_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cycle("mc20_flush", 1, 0, 0, 1, 0, 6'b000000, 1, 0);
    cycle("mc20_c7", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Flush beats mc_start
    cycle("flstart_c1", 0, 1, 5, 1, 0, 6'b000000, 0, 0);
    cycle("flstart_c2", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // mc_start while running is ignored
    cycle("ign_c1", 0, 1, 3, 0, 0, 6'b001111, 0, 0);
    cycle("ign_c2", 0, 1, 10, 0, 0, 6'b001111, 1, 0);
    cycle("ign_c3", 0, 0, 0, 0, 0, 6'b000000, 1, 1);
    cycle("ign_c4", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // perf_clr concurrent with stall
    cycle("clr_c1", 1, 0, 0, 0, 1, 6'b000111, 0, 0);
    cycle("clr_c2", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Saturation on 4-bit counter build
    @(posedge clk); #1; id4 = 1'b1;
    repeat (14) @(posedge clk);
    #1; check("sat4.preload_sc", 32'(sc4), 32'hE);
    check("sat4.preload_bc", 32'(bc4), 32'hE);
    repeat (3) @(posedge clk);
    #1; check("sat4.hold_sc", 32'(sc4), 32'hF);
    check("sat4.hold_bc", 32'(bc4), 32'hF);
    clr4 = 1'b1;
    @(posedge clk); #1; clr4 = 1'b0; id4 = 1'b0;
    check("sat4.clr_sc", 32'(sc4), 32'h0);
    check("sat4.clr_bc", 32'(bc4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
